// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: immediate-type codes and major opcodes.
package rv_decode_pkg;

    typedef enum logic [2:0] {
        IMM_R   = 3'b000,
        IMM_I   = 3'b001,
        IMM_S   = 3'b010,
        IMM_B   = 3'b011,
        IMM_U   = 3'b100,
        IMM_J   = 3'b101,
        IMM_CSR = 3'b110
    } imm_type_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_generator.sv
// Builds the sign/zero-extended immediate for a given immediate type.
module imm_generator
    import rv_decode_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            // CSR immediate forms carry a 5-bit zero-extended uimm in the rs1 field
            IMM_CSR: imm = {27'b0, instr[19:15]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/opcode_classifier.sv
// Maps an instruction's major opcode to its immediate type and flags unsupported encodings.
module opcode_classifier
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output imm_type_e   imm_type,
    output logic        illegal
);

    logic unused_bits;
    assign unused_bits = ^{instr[31:15], instr[13:7]};

    always_comb begin
        imm_type = IMM_I;
        illegal  = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                    imm_type = IMM_U;
            OPC_JAL:                               imm_type = IMM_J;
            OPC_BRANCH:                            imm_type = IMM_B;
            OPC_STORE:                             imm_type = IMM_S;
            OPC_OP:                                imm_type = IMM_R;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM: imm_type = IMM_I;
            OPC_SYSTEM:                            imm_type = instr[14] ? IMM_CSR : IMM_I;
            // every legal opcode ends in 2'b11, so compressed/garbage words land here
            default:                               illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_imm_stage.sv
// Decode stage: 2-entry skid buffer holding classified instructions, head drives imm_generator.
// state | meaning
// EMPTY | no entry held
// ONE   | head valid
// TWO   | head and skid valid, input stalled
module id_imm_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IN_INSTR,
    input  logic [XLEN-1:0]  IN_PC,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_INSTR,
    output logic [XLEN-1:0]  OUT_PC,
    output logic [2:0]       OUT_IMM_TYPE,
    output logic [31:0]      OUT_IMM,
    output logic             OUT_ILLEGAL,
    output logic [CNT_W-1:0] ILLEGAL_CNT
);

    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10} state_e;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [31:0]     head_instr_q, head_instr_d, skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
    imm_type_e       head_type_q, head_type_d, skid_type_q, skid_type_d;
    logic            head_ill_q, head_ill_d, skid_ill_q, skid_ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    imm_type_e in_type;
    logic      in_ill;
    logic      accept, retire;

    opcode_classifier u_classifier (
        .instr    (IN_INSTR),
        .imm_type (in_type),
        .illegal  (in_ill)
    );

    imm_generator u_imm_gen (
        .instr    (head_instr_q[31:7]),
        .imm_type (head_type_q),
        .imm      (OUT_IMM)
    );

    assign OUT_VALID    = (state_q == ONE) || (state_q == TWO);
    assign IN_READY     = in_ready_q;
    assign OUT_INSTR    = head_instr_q;
    assign OUT_PC       = head_pc_q;
    assign OUT_IMM_TYPE = head_type_q;
    assign OUT_ILLEGAL  = head_ill_q;
    assign ILLEGAL_CNT  = cnt_q;

    assign accept = IN_VALID && in_ready_q;
    assign retire = OUT_VALID && OUT_READY;

    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        head_type_d  = head_type_q;
        head_ill_d   = head_ill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_type_d  = skid_type_q;
        skid_ill_d   = skid_ill_q;
        cnt_d        = cnt_q;

        if (FLUSH) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                ONE: begin
                    if (accept) begin
                        if (retire) begin
                            head_instr_d = IN_INSTR;
                            head_pc_d    = IN_PC;
                            head_type_d  = in_type;
                            head_ill_d   = in_ill;
                        end else begin
                            skid_instr_d = IN_INSTR;
                            skid_pc_d    = IN_PC;
                            skid_type_d  = in_type;
                            skid_ill_d   = in_ill;
                            state_d      = TWO;
                        end
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (retire) begin
                        head_instr_d = skid_instr_q;
                        head_pc_d    = skid_pc_q;
                        head_type_d  = skid_type_q;
                        head_ill_d   = skid_ill_q;
                        state_d      = ONE;
                    end
                end
                default: begin
                    if (accept) begin
                        head_instr_d = IN_INSTR;
                        head_pc_d    = IN_PC;
                        head_type_d  = in_type;
                        head_ill_d   = in_ill;
                        state_d      = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            endcase

            if (accept && in_ill && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_type_q  <= IMM_I;
            head_ill_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_type_q  <= IMM_I;
            skid_ill_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            head_type_q  <= head_type_d;
            head_ill_q   <= head_ill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_type_q  <= skid_type_d;
            skid_ill_q   <= skid_ill_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_imm_stage.sv
// Directed bench for id_imm_stage; a second instance with a 2-bit counter checks saturation.
module tb_id_imm_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_INSTR;
    logic [31:0] IN_PC;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_INSTR;
    logic [31:0] OUT_PC;
    logic [2:0]  OUT_IMM_TYPE;
    logic [31:0] OUT_IMM;
    logic        OUT_ILLEGAL;
    logic [15:0] ILLEGAL_CNT;

    logic        in_ready2, out_valid2, out_illegal2;
    logic [31:0] out_instr2, out_pc2, out_imm2;
    logic [2:0]  out_type2;
    logic [1:0]  illegal_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    id_imm_stage #(.XLEN(32), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR),
        .OUT_PC(OUT_PC), .OUT_IMM_TYPE(OUT_IMM_TYPE), .OUT_IMM(OUT_IMM),
        .OUT_ILLEGAL(OUT_ILLEGAL), .ILLEGAL_CNT(ILLEGAL_CNT)
    );

    id_imm_stage #(.XLEN(32), .CNT_W(2)) u_dut_sat (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready2),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH),
        .OUT_VALID(out_valid2), .OUT_READY(OUT_READY), .OUT_INSTR(out_instr2),
        .OUT_PC(out_pc2), .OUT_IMM_TYPE(out_type2), .OUT_IMM(out_imm2),
        .OUT_ILLEGAL(out_illegal2), .ILLEGAL_CNT(illegal_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [2:0] typ, input logic [31:0] imm, input logic ill);
        chk({tag, "_valid"}, {31'b0, OUT_VALID}, 32'd1);
        chk({tag, "_instr"}, OUT_INSTR, instr);
        chk({tag, "_pc"}, OUT_PC, pc);
        chk({tag, "_type"}, {29'b0, OUT_IMM_TYPE}, {29'b0, typ});
        chk({tag, "_imm"}, OUT_IMM, imm);
        chk({tag, "_ill"}, {31'b0, OUT_ILLEGAL}, {31'b0, ill});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'b0, OUT_VALID}, 32'd0);
        chk({tag, "_ready"}, {31'b0, IN_READY}, 32'd1);
        chk({tag, "_instr"}, OUT_INSTR, 32'd0);
        chk({tag, "_pc"}, OUT_PC, 32'd0);
        chk({tag, "_type"}, {29'b0, OUT_IMM_TYPE}, 32'd1);
        chk({tag, "_imm"}, OUT_IMM, 32'd0);
        chk({tag, "_ill"}, {31'b0, OUT_ILLEGAL}, 32'd0);
        chk({tag, "_cnt"}, {16'b0, ILLEGAL_CNT}, 32'd0);
        chk({tag, "_cnt_sat"}, {30'b0, illegal_cnt2}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; IN_INSTR = '0; IN_PC = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
        #3;
        chk_reset("reset");
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1;

        // ADDI x1,x0,-1 into an empty stage
        IN_VALID = 1'b1; IN_INSTR = 32'hFFF00093; IN_PC = 32'h100; OUT_READY = 1'b1;
        step();
        chk_head("addi", 32'hFFF00093, 32'h100, 3'b001, 32'hFFFFFFFF, 1'b0);
        chk("addi_ready", {31'b0, IN_READY}, 32'd1);

        // back-to-back LUI then BEQ at full throughput
        IN_INSTR = 32'h123450B7; IN_PC = 32'h104;
        step();
        chk_head("lui", 32'h123450B7, 32'h104, 3'b100, 32'h12345000, 1'b0);
        chk("lui_ready", {31'b0, IN_READY}, 32'd1);
        IN_INSTR = 32'hFE000EE3; IN_PC = 32'h108;
        step();
        chk_head("beq", 32'hFE000EE3, 32'h108, 3'b011, 32'hFFFFFFFC, 1'b0);
        chk("beq_ready", {31'b0, IN_READY}, 32'd1);
        IN_VALID = 1'b0;
        step();
        chk("drain_valid", {31'b0, OUT_VALID}, 32'd0);

        // CSRRWI then STORE with execute stalled: fills skid
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN_INSTR = 32'h3002D073; IN_PC = 32'h200;
        step();
        chk_head("csr_one", 32'h3002D073, 32'h200, 3'b110, 32'h00000005, 1'b0);
        chk("csr_one_ready", {31'b0, IN_READY}, 32'd1);
        IN_INSTR = 32'h00112423; IN_PC = 32'h204;
        step();
        chk_head("csr_two", 32'h3002D073, 32'h200, 3'b110, 32'h00000005, 1'b0);
        chk("two_ready", {31'b0, IN_READY}, 32'd0);
        IN_VALID = 1'b0;
        step();
        chk_head("csr_hold", 32'h3002D073, 32'h200, 3'b110, 32'h00000005, 1'b0);
        chk("hold_ready", {31'b0, IN_READY}, 32'd0);
        OUT_READY = 1'b1;
        step();
        chk_head("store", 32'h00112423, 32'h204, 3'b010, 32'h00000008, 1'b0);
        chk("store_ready", {31'b0, IN_READY}, 32'd1);

        // refill to TWO, then flush with an instruction offered
        OUT_READY = 1'b0; IN_VALID = 1'b1; IN_INSTR = 32'hFFF00093; IN_PC = 32'h300;
        step();
        chk("refill_ready", {31'b0, IN_READY}, 32'd0);
        FLUSH = 1'b1; IN_INSTR = 32'h123450B7; IN_PC = 32'h400;
        step();
        chk("flush2_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("flush2_ready", {31'b0, IN_READY}, 32'd1);
        FLUSH = 1'b0; IN_VALID = 1'b0;
        step();
        step();
        chk("post_flush_valid", {31'b0, OUT_VALID}, 32'd0);

        // flush in ONE while an accepted-looking illegal word is offered: dropped, not counted
        IN_VALID = 1'b1; IN_INSTR = 32'hFFF00093; IN_PC = 32'h500;
        step();
        chk("one_valid", {31'b0, OUT_VALID}, 32'd1);
        FLUSH = 1'b1; IN_INSTR = 32'h0000007F; IN_PC = 32'h504;
        step();
        chk("flush1_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("flush1_cnt", {16'b0, ILLEGAL_CNT}, 32'd0);
        FLUSH = 1'b0; IN_VALID = 1'b0;
        step();
        chk("flush1_stays", {31'b0, OUT_VALID}, 32'd0);

        // illegal encodings: three 0x7F then one 0x01
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN_INSTR = 32'h0000007F;
        for (int i = 1; i <= 3; i++) begin
            IN_PC = 32'h600 + 32'(i * 4);
            step();
            chk_head("ill7f", 32'h0000007F, 32'h600 + 32'(i * 4), 3'b001, 32'h0, 1'b1);
            chk("ill7f_cnt", {16'b0, ILLEGAL_CNT}, 32'(i));
            chk("ill7f_cnt_sat", {30'b0, illegal_cnt2}, 32'(i));
        end
        IN_INSTR = 32'h00000001; IN_PC = 32'h610;
        step();
        chk_head("ill01", 32'h00000001, 32'h610, 3'b001, 32'h0, 1'b1);
        chk("ill01_cnt", {16'b0, ILLEGAL_CNT}, 32'd4);
        chk("ill01_cnt_sat", {30'b0, illegal_cnt2}, 32'd3);

        // async reset in state TWO
        OUT_READY = 1'b0; IN_INSTR = 32'hFFF00093; IN_PC = 32'h700;
        step();
        chk("pre_rst_ready", {31'b0, IN_READY}, 32'd0);
        chk("pre_rst_valid", {31'b0, OUT_VALID}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk_reset("async_rst");
        IN_VALID = 1'b0;
        step();
        RST = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_imm_stage.md
Name: id_imm_stage

Overview:
- Decode-stage controller for the immediate generator.
- Accepts fetched instructions over a valid/ready handshake and classifies each by opcode into an immediate type.
- Registers instruction, PC and type into a 2-entry skid-buffered pipeline stage. Drives the imm_generator from the head entry and presents the immediate to execute over a second valid/ready handshake.
- Also tracks flushes and counts illegal encodings.

Parameters:
- XLEN, 32, data/PC width; fixed at 32.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- IN_VALID  input  1  fetch has an instruction.
- IN_READY  output  1  stage can accept this cycle.
- IN_INSTR  input  32  instruction word.
- IN_PC  input  32  instruction address.
- FLUSH  input  1  discard all held entries (branch/trap redirect).
- OUT_VALID  output  1  head entry valid.
- OUT_READY  input  1  execute accepts the head entry.
- OUT_INSTR  output  32  head instruction.
- OUT_PC  output  32  head PC.
- OUT_IMM_TYPE  output  3  head immediate type, encoded R=000 I=001 S=010 B=011 U=100 J=101 CSR=110.
- OUT_IMM  output  32  immediate from imm_generator on the head entry.
- OUT_ILLEGAL  output  1  head opcode unsupported.
- ILLEGAL_CNT  output  CNT_W  illegal instructions accepted since reset, saturating.

Behaviour:
- Reset values (asynchronous):
  - Both entries invalid.
  - OUT_VALID=0, IN_READY=1, ILLEGAL_CNT=0.
  - OUT_INSTR/OUT_PC=0, OUT_IMM_TYPE=001, OUT_ILLEGAL=0.
  - OUT_IMM therefore reads 0.
- Opcode classification on IN_INSTR[6:0], computed before registering:
  - 0110111 LUI → U; 0010111 AUIPC → U.
  - 1101111 JAL → J.
  - 1100111 JALR → I.
  - 1100011 BRANCH → B.
  - 0000011 LOAD → I.
  - 0100011 STORE → S.
  - 0010011 OP-IMM → I.
  - 0110011 OP → R.
  - 0001111 MISC-MEM → I.
  - 1110011 SYSTEM → CSR if funct3[2]=1, else I.
  - Anything else, including IN_INSTR[1:0]!=11 → type I with illegal=1.
- State machine over occupancy: EMPTY, ONE (head valid), TWO (head+skid valid).
  - Accept = IN_VALID && IN_READY.
  - Retire = OUT_VALID && OUT_READY.
  - EMPTY: accept → ONE; the entry loads the head register.
  - ONE, accept and retire together → stays ONE; the new entry replaces the head.
  - ONE, accept only → TWO; the new entry goes to skid.
  - ONE, retire only → EMPTY.
  - TWO, retire → ONE; skid moves to head. Accept cannot occur because IN_READY=0.
  - State 11 is unreachable; treat it as EMPTY.
- IN_READY is registered: equals (next state != TWO). It never depends combinationally on OUT_READY.
- Latency: an instruction accepted in cycle N is presented with OUT_VALID=1 in cycle N+1 when the stage was empty. Full throughput is 1 instruction/cycle with OUT_READY held high.
- OUT_* fields are stable while OUT_VALID=1 and OUT_READY=0.
- OUT_IMM is combinational from head OUT_INSTR[31:7] and OUT_IMM_TYPE via the imm_generator instance. There is no additional register.
- FLUSH has priority over all other events:
  - Next state EMPTY, IN_READY=1 the following cycle.
  - Any instruction offered in the flush cycle is dropped, not counted, and leaves no state.
  - A retire in the same cycle is still a valid handshake for execute.
- ILLEGAL_CNT increments by 1 on each accepted illegal instruction (accept && illegal && !FLUSH). It holds at all-ones; there is no wrap. It is not cleared by FLUSH.
- Reset mid-transfer clears everything immediately, regardless of CLK.

Decomposition:
- Shared package/header rv_decode_pkg:
  - IMM_TYPE codes R/I/S/B/U/J/CSR (3-bit).
  - RV32I opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM).
- Sub-modules:
  - imm_generator is instantiated unchanged.
  - The opcode classifier is one natural sub-module, opcode_classifier: INSTR[31:0] → IMM_TYPE[2:0], ILLEGAL.

Test Plan:
- ADDI x1,x0,-1, 0xFFF00093, PC 0x100, OUT_READY=1 → next cycle OUT_VALID=1, TYPE=001, IMM=0xFFFFFFFF, OUT_PC=0x100, ILLEGAL=0.
- Back-to-back LUI 0x123450B7 then BEQ 0xFE000EE3 with OUT_READY=1 → consecutive cycles: IMM 0x12345000 type 100, then IMM 0xFFFFFFFC type 011; IN_READY stays 1.
- CSRRWI 0x3002D073 then STORE 0x00112423 with OUT_READY=0 → state TWO, IN_READY=0 next cycle. Outputs hold CSR type 110, IMM=0x00000005. Raise OUT_READY → head becomes STORE, type 010, IMM=0x00000008.
- FLUSH asserted in state TWO while IN_VALID=1 → OUT_VALID=0 and IN_READY=1 next cycle; no offered instruction appears later.
- Opcode 0x0000007F accepted three times, then 0x00000001 once → OUT_ILLEGAL=1 each time, type 001, ILLEGAL_CNT=4. With CNT_W=2, the counter saturates at 3.
- RST asserted asynchronously mid-stream in state TWO → all outputs return to reset values before the next CLK edge; ILLEGAL_CNT=0.
